// File: rtl/retirement_serializer.sv
// Retirement serializer: captures up to NRET retired instructions per cycle as one
// group in a FIFO and replays the valid lanes one beat at a time over valid/ready.
module retirement_serializer #(
  parameter int NRET       = 2,
  parameter int DEPTH      = 16,
  parameter int XLEN       = 64,
  parameter int INST_LEN   = 32,
  parameter int CAUSE_LEN  = 5,
  parameter int PRIV_LEN   = 2,
  parameter int DROP_CNT_W = 16,
  localparam int LANE_W    = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NRET-1:0]               valid_i,
  input  logic [NRET-1:0][XLEN-1:0]     pc_i,
  input  logic [NRET-1:0][INST_LEN-1:0] inst_data_i,
  input  logic [NRET-1:0]               compressed_i,
  input  logic                          exception_i,
  input  logic                          interrupt_i,
  input  logic                          eret_i,
  input  logic [CAUSE_LEN-1:0]          cause_i,
  input  logic [XLEN-1:0]               tval_i,
  input  logic [PRIV_LEN-1:0]           priv_i,
  input  logic                          flush_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          instr_o,
  output logic [LANE_W-1:0]             lane_o,
  output logic [XLEN-1:0]               pc_o,
  output logic [INST_LEN-1:0]           inst_data_o,
  output logic                          compressed_o,
  output logic                          exception_o,
  output logic                          interrupt_o,
  output logic                          eret_o,
  output logic [CAUSE_LEN-1:0]          cause_o,
  output logic [XLEN-1:0]               tval_o,
  output logic [PRIV_LEN-1:0]           priv_o,
  output logic                          last_o,
  output logic                          overflow_o,
  output logic [DROP_CNT_W-1:0]         drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [NRET-1:0]               mask_mem  [DEPTH];
  logic [NRET-1:0][XLEN-1:0]     pc_mem    [DEPTH];
  logic [NRET-1:0][INST_LEN-1:0] inst_mem  [DEPTH];
  logic [NRET-1:0]               comp_mem  [DEPTH];
  logic                          exc_mem   [DEPTH];
  logic                          intr_mem  [DEPTH];
  logic                          eret_mem  [DEPTH];
  logic [CAUSE_LEN-1:0]          cause_mem [DEPTH];
  logic [XLEN-1:0]               tval_mem  [DEPTH];
  logic [PRIV_LEN-1:0]           priv_mem  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [LANE_W-1:0] lane_ptr;

  logic              full, empty, group_seen, push, drop, pop, handshake;
  logic [NRET-1:0]   head_mask;
  logic              cur_found, nxt_found, is_last;
  logic [LANE_W-1:0] cur_lane, nxt_lane;

  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign empty      = (count == '0);
  assign group_seen = (|valid_i) || exception_i || interrupt_i;
  assign push       = group_seen && !full && !flush_i;
  assign drop       = group_seen && full && !flush_i;
  assign handshake  = valid_o && ready_i;
  assign pop        = handshake && is_last;
  assign head_mask  = mask_mem[rd_ptr];

  // Current lane is the lowest set mask bit at or above the pointer; the next
  // set bit above it decides whether this beat closes the group.
  always_comb begin
    cur_found = 1'b0;
    cur_lane  = '0;
    nxt_found = 1'b0;
    nxt_lane  = '0;
    for (int i = 0; i < NRET; i++) begin
      if (!cur_found && head_mask[i] && (i >= int'(lane_ptr))) begin
        cur_found = 1'b1;
        cur_lane  = LANE_W'(i);
      end
    end
    for (int i = 0; i < NRET; i++) begin
      if (cur_found && !nxt_found && head_mask[i] && (i > int'(cur_lane))) begin
        nxt_found = 1'b1;
        nxt_lane  = LANE_W'(i);
      end
    end
    is_last = !nxt_found;
  end

  always_comb begin
    valid_o      = 1'b0;
    instr_o      = 1'b0;
    lane_o       = '0;
    pc_o         = '0;
    inst_data_o  = '0;
    compressed_o = 1'b0;
    exception_o  = 1'b0;
    interrupt_o  = 1'b0;
    eret_o       = 1'b0;
    cause_o      = '0;
    tval_o       = '0;
    priv_o       = '0;
    last_o       = 1'b0;
    if (!empty) begin
      valid_o = 1'b1;
      priv_o  = priv_mem[rd_ptr];
      last_o  = is_last;
      if (cur_found) begin
        instr_o      = 1'b1;
        lane_o       = cur_lane;
        pc_o         = pc_mem[rd_ptr][cur_lane];
        inst_data_o  = inst_mem[rd_ptr][cur_lane];
        compressed_o = comp_mem[rd_ptr][cur_lane];
      end
      // Group context rides only on the closing beat.
      if (is_last) begin
        exception_o = exc_mem[rd_ptr];
        interrupt_o = intr_mem[rd_ptr];
        eret_o      = eret_mem[rd_ptr];
        cause_o     = cause_mem[rd_ptr];
        tval_o      = tval_mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mask_mem[wr_ptr]  <= valid_i;
      pc_mem[wr_ptr]    <= pc_i;
      inst_mem[wr_ptr]  <= inst_data_i;
      comp_mem[wr_ptr]  <= compressed_i;
      exc_mem[wr_ptr]   <= exception_i;
      intr_mem[wr_ptr]  <= interrupt_i;
      eret_mem[wr_ptr]  <= eret_i;
      cause_mem[wr_ptr] <= cause_i;
      tval_mem[wr_ptr]  <= tval_i;
      priv_mem[wr_ptr]  <= priv_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lane_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lane_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (handshake) begin
        if (is_last) begin
          rd_ptr   <= rd_ptr + 1'b1;
          lane_ptr <= '0;
        end else begin
          lane_ptr <= nxt_lane;
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Drop statistics survive flush and only clear on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_retirement_serializer.sv
// Scoreboard bench for retirement_serializer (NRET=4, DEPTH=4): a queue-based group
// model expands each accepted group into expected beats; a monitor compares every cycle.
module tb_retirement_serializer;

  localparam int NRET  = 4;
  localparam int DEPTH = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [3:0]           valid_i;
  logic [3:0][63:0]     pc_i;
  logic [3:0][31:0]     inst_data_i;
  logic [3:0]           compressed_i;
  logic                 exception_i, interrupt_i, eret_i;
  logic [4:0]           cause_i;
  logic [63:0]          tval_i;
  logic [1:0]           priv_i;
  logic                 flush_i;
  logic                 valid_o;
  logic                 ready_i;
  logic                 instr_o;
  logic [1:0]           lane_o;
  logic [63:0]          pc_o;
  logic [31:0]          inst_data_o;
  logic                 compressed_o;
  logic                 exception_o, interrupt_o, eret_o;
  logic [4:0]           cause_o;
  logic [63:0]          tval_o;
  logic [1:0]           priv_o;
  logic                 last_o;
  logic                 overflow_o;
  logic [15:0]          drop_cnt_o;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [1:0]  lane;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        comp;
    logic        exc;
    logic        intr;
    logic        eret;
    logic [4:0]  cause;
    logic [63:0] tval;
    logic [1:0]  priv;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          occupancy = 0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = '0;
  int          n_checks = 0;
  int          n_fails = 0;

  retirement_serializer #(
    .NRET(NRET), .DEPTH(DEPTH), .XLEN(64), .INST_LEN(32),
    .CAUSE_LEN(5), .PRIV_LEN(2), .DROP_CNT_W(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .pc_i(pc_i),
    .inst_data_i(inst_data_i), .compressed_i(compressed_i),
    .exception_i(exception_i), .interrupt_i(interrupt_i), .eret_i(eret_i),
    .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .lane_o(lane_o),
    .pc_o(pc_o), .inst_data_o(inst_data_o), .compressed_o(compressed_o),
    .exception_o(exception_o), .interrupt_o(interrupt_o), .eret_o(eret_o),
    .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o), .last_o(last_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Turn one captured group into the beat list a consumer should see.
  task automatic expand_group();
    beat_t b;
    int    hi;
    hi = -1;
    for (int i = 0; i < NRET; i++) if (valid_i[i]) hi = i;
    if (hi < 0) begin
      b = '0;
      b.valid = 1'b1; b.priv = priv_i; b.last = 1'b1;
      b.exc = exception_i; b.intr = interrupt_i; b.eret = eret_i;
      b.cause = cause_i; b.tval = tval_i;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < NRET; i++) begin
        if (valid_i[i]) begin
          b = '0;
          b.valid = 1'b1; b.instr = 1'b1; b.lane = 2'(i);
          b.pc = pc_i[i]; b.inst = inst_data_i[i]; b.comp = compressed_i[i];
          b.priv = priv_i;
          if (i == hi) begin
            b.last = 1'b1;
            b.exc = exception_i; b.intr = interrupt_i; b.eret = eret_i;
            b.cause = cause_i; b.tval = tval_i;
          end
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Reference model: group-level FIFO occupancy plus a flat queue of pending beats.
  initial begin
    beat_t popped;
    logic  was_full;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        exp_q.delete(); occupancy = 0; m_ovf = 1'b0; m_drop = '0;
      end else if (flush_i) begin
        exp_q.delete(); occupancy = 0;
      end else begin
        was_full = (occupancy == DEPTH);
        if (exp_q.size() > 0 && ready_i) begin
          popped = exp_q.pop_front();
          if (popped.last) occupancy--;
        end
        if ((|valid_i) || exception_i || interrupt_i) begin
          if (!was_full) begin
            expand_group();
            occupancy++;
          end else begin
            m_ovf = 1'b1;
            if (m_drop != 16'hffff) m_drop++;
          end
        end
      end
    end
  end

  task automatic check_output();
    beat_t act, exp;
    act = {valid_o, instr_o, lane_o, pc_o, inst_data_o, compressed_o, exception_o,
           interrupt_o, eret_o, cause_o, tval_o, priv_o, last_o};
    exp = (exp_q.size() > 0) ? exp_q[0] : '0;
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL beat t=%0t actual=%h required=%h", $time, act, exp);
    end
    n_checks++;
    if ({overflow_o, drop_cnt_o} !== {m_ovf, m_drop}) begin
      n_fails++;
      $display("[TB] FAIL drop_stats t=%0t actual=%b/%0d required=%b/%0d",
               $time, overflow_o, drop_cnt_o, m_ovf, m_drop);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) check_output();
    end
  end

  task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] v, input logic exc, input logic intr,
                                input logic eret, input logic [4:0] cause,
                                input logic [63:0] tval, input logic [1:0] priv,
                                input logic [63:0] pc_base, input logic flush,
                                input logic rdy);
    @(negedge clk_i);
    valid_i = v; exception_i = exc; interrupt_i = intr; eret_i = eret;
    cause_i = cause; tval_i = tval; priv_i = priv; flush_i = flush; ready_i = rdy;
    for (int i = 0; i < NRET; i++) begin
      pc_i[i]         = pc_base + 64'(4 * i);
      inst_data_i[i]  = $urandom;
      compressed_i[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++)
      apply_stimulus(4'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 2'd3, 64'd0, 1'b0, rdy);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] v;
    logic       exc, intr, fl;
    rst_ni = 1'b0;
    valid_i = '0; pc_i = '0; inst_data_i = '0; compressed_i = '0;
    exception_i = 0; interrupt_i = 0; eret_i = 0; cause_i = '0; tval_i = '0;
    priv_i = '0; flush_i = 0; ready_i = 0;
    repeat (3) @(negedge clk_i);
    check_value("reset_valid", 64'(valid_o), 64'd0);
    check_value("reset_pc", pc_o, 64'd0);
    check_value("reset_ovf", 64'(overflow_o), 64'd0);
    check_value("reset_drop", 64'(drop_cnt_o), 64'd0);
    rst_ni = 1'b1;

    $display("[TB] two-lane group");
    apply_stimulus(4'b0011, 0, 0, 0, 5'd0, 64'd0, 2'd3, 64'h100, 0, 1);
    idle(4, 1);

    $display("[TB] sparse group with exception");
    apply_stimulus(4'b1010, 1, 0, 0, 5'd2, 64'hdead, 2'd1, 64'h200, 0, 1);
    idle(4, 1);

    $display("[TB] interrupt-only and eret-alone");
    apply_stimulus(4'b0000, 0, 1, 0, 5'd7, 64'h55, 2'd0, 64'h0, 0, 1);
    apply_stimulus(4'b0000, 0, 0, 1, 5'd3, 64'h66, 2'd0, 64'h0, 0, 1);
    idle(4, 1);

    $display("[TB] backpressure");
    apply_stimulus(4'b0011, 0, 0, 1, 5'd0, 64'd0, 2'd2, 64'h300, 0, 0);
    idle(5, 0);
    check_value("stall_valid", 64'(valid_o), 64'd1);
    check_value("stall_pc", pc_o, 64'h300);
    idle(4, 1);

    $display("[TB] overflow");
    for (int g = 0; g < 6; g++)
      apply_stimulus(4'b0001, 0, 0, 0, 5'd0, 64'd0, 2'd1, 64'h1000 + 64'(g * 16), 0, 0);
    idle(1, 0);
    check_value("ovf_drop_cnt", 64'(drop_cnt_o), 64'd2);
    check_value("ovf_sticky", 64'(overflow_o), 64'd1);
    idle(8, 1);
    check_value("ovf_drained", 64'(valid_o), 64'd0);

    $display("[TB] flush");
    for (int g = 0; g < 3; g++)
      apply_stimulus(4'b0110, 0, 0, 0, 5'd0, 64'd0, 2'd1, 64'h2000 + 64'(g * 16), 0, 0);
    apply_stimulus(4'b0000, 0, 0, 0, 5'd0, 64'd0, 2'd0, 64'h0, 1, 0);
    idle(1, 1);
    check_value("flush_valid", 64'(valid_o), 64'd0);
    check_value("flush_ovf_kept", 64'(overflow_o), 64'd1);
    idle(2, 1);

    $display("[TB] reset mid-group");
    apply_stimulus(4'b1111, 1, 0, 0, 5'd9, 64'hbeef, 2'd3, 64'h4000, 0, 1);
    idle(2, 1);
    #2 rst_ni = 1'b0;
    #1;
    check_value("arst_valid", 64'(valid_o), 64'd0);
    check_value("arst_pc", pc_o, 64'd0);
    check_value("arst_last", 64'(last_o), 64'd0);
    check_value("arst_ovf", 64'(overflow_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] random traffic");
    for (int c = 0; c < 2000; c++) begin
      v    = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      exc  = ($urandom_range(0, 7) == 0);
      intr = ($urandom_range(0, 11) == 0);
      fl   = ($urandom_range(0, 99) == 0);
      if (fl) begin v = '0; exc = 0; intr = 0; end
      apply_stimulus(v, exc, intr, 1'($urandom_range(0, 1)), 5'($urandom),
                     {$urandom, $urandom}, 2'($urandom), {32'd0, $urandom},
                     fl, ($urandom_range(0, 3) != 0));
    end
    idle(40, 1);
    check_value("final_drained", 64'(valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
